ula_sequencial: RTL and testbench

//  Parametrised, clocked successor of the 4-bit combinational ULA. It accepts
//  N-bit operands on a start strobe and returns a registered 2N-bit result with Z/OV/COUT/ERR flags.
//  Add/sub/logic complete in 1 cycle; mult (shift-add) and div (restoring) iterate over N cycles.
//  It sits between the operand/select registers and the display/result register file.

---
 rtl/ula_sequencial_if.sv | 36 +++
 rtl/ula_sequencial.sv | 193 +++++++++++++++++++
 tb/tb_ula_sequencial.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ula_sequencial_if.sv
// ----------------------------------------------------------------------------
// ula_sequencial_if
// Operand/result bundle between the operand/select registers and the
// sequential ULA.
//   master : drives start, A, B, Cin, Bin, Sel; observes S and the status
//   slave  : the ULA itself; takes the operands, returns S, Z, OV, COUT, ERR,
//            busy, done
// Parameter N : operand width (result width 2N); must match the ULA's N.
// ----------------------------------------------------------------------------
interface ula_sequencial_if #(
   parameter int N = 4
);
   logic           start;
   logic [N-1:0]   A;
   logic [N-1:0]   B;
   logic           Cin;
   logic           Bin;
   logic [2:0]     Sel;
   logic [2*N-1:0] S;
   logic           Z;
   logic           OV;
   logic           COUT;
   logic           ERR;
   logic           busy;
   logic           done;

   modport master (
      output start, A, B, Cin, Bin, Sel,
      input  S, Z, OV, COUT, ERR, busy, done
   );

   modport slave (
      input  start, A, B, Cin, Bin, Sel,
      output S, Z, OV, COUT, ERR, busy, done
   );
endinterface

// File: rtl/ula_sequencial.sv
// ----------------------------------------------------------------------------
// ula_sequencial
// Clocked N-bit ULA. Operands are latched on an accepted start strobe; the
// 2N-bit result and its flags are registered and announced by a one-cycle
// done pulse. soma/sub/logic and every error case take 1 cycle; mult
// (shift-add) and div/resto (restoring) iterate N cycles, plus one to publish.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high; aborts any running operation
//   bus  : ula_sequencial_if.slave
//          start, A, B, Cin, Bin, Sel -> operands and request
//          S, Z, OV, COUT, ERR, busy, done <- registered result and status
// Sel: 000 soma, 001 sub, 010 mult, 011 div, 100 and, 101 or, 110 xor,
//      111 resto (only with ULA_RESTO_EN, otherwise reported as ERR)
// Build option: define ULA_RESTO_EN to make Sel=111 return the remainder.
// ----------------------------------------------------------------------------
module ula_sequencial #(
   parameter int N = 4
) (
   input logic            clk,
   input logic            rst,
   ula_sequencial_if.slave bus
);
   localparam int CNT_W = $clog2(N + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [N-1:0]     r_a;
   logic [N-1:0]     r_b;
   logic             r_cin;
   logic             r_bin;
   logic [2:0]       r_sel;
   logic [2*N-1:0]   r_acc;
   logic [2*N-1:0]   r_mcand;
   logic [N-1:0]     r_mpl;
   logic [N-1:0]     r_q;
   logic [N-1:0]     r_rem;
   logic [2*N-1:0]   r_s;
   logic             r_z;
   logic             r_ov;
   logic             r_cout;
   logic             r_err;
   logic             r_busy;
   logic             r_done;

   logic             w_go_calc;
   logic [N:0]       w_sum;
   logic [N:0]       w_dif;
   logic [N:0]       w_trial;
   logic             w_ge;
   logic [2*N-1:0]   w_s;
   logic             w_ov;
   logic             w_cout;
   logic             w_err;

   // Only mult and a divide with a non-zero divisor need the iterative path;
   // divide-by-zero falls straight through to the 1-cycle error result.
   always_comb begin
      w_go_calc = 1'b0;
      case (bus.Sel)
         3'b010:  w_go_calc = 1'b1;
         3'b011:  w_go_calc = |bus.B;
`ifdef ULA_RESTO_EN
         3'b111:  w_go_calc = |bus.B;
`endif
         default: w_go_calc = 1'b0;
      endcase
   end

   // Restoring divider step: shift next dividend bit into the partial remainder.
   assign w_trial = {r_rem, r_q[N-1]};
   assign w_ge    = (w_trial >= {1'b0, r_b});

   assign w_sum = {1'b0, r_a} + {1'b0, r_b} + {{N{1'b0}}, r_cin};
   assign w_dif = {1'b0, r_a} - {1'b0, r_b} - {{N{1'b0}}, r_bin};

   always_comb begin
      w_s    = '0;
      w_ov   = 1'b0;
      w_cout = 1'b0;
      w_err  = 1'b0;
      case (r_sel)
         3'b000: begin
            w_s    = {{(N-1){1'b0}}, w_sum};
            w_cout = w_sum[N];
            w_ov   = (r_a[N-1] == r_b[N-1]) && (w_sum[N-1] != r_a[N-1]);
         end
         3'b001: begin
            w_s    = {{(N-1){1'b0}}, w_dif};
            w_cout = w_dif[N];
            w_ov   = (r_a[N-1] != r_b[N-1]) && (w_dif[N-1] != r_a[N-1]);
         end
         3'b010: begin
            w_s  = r_acc;
            w_ov = |r_acc[2*N-1:N];
         end
         3'b011: begin
            if (r_b == '0) w_err = 1'b1;
            else           w_s   = {{N{1'b0}}, r_q};
         end
         3'b100: w_s = {{N{1'b0}}, r_a & r_b};
         3'b101: w_s = {{N{1'b0}}, r_a | r_b};
         3'b110: w_s = {{N{1'b0}}, r_a ^ r_b};
         default: begin
`ifdef ULA_RESTO_EN
            if (r_b == '0) w_err = 1'b1;
            else           w_s   = {{N{1'b0}}, r_rem};
`else
            w_err = 1'b1;
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_cin   <= 1'b0;
         r_bin   <= 1'b0;
         r_sel   <= '0;
         r_acc   <= '0;
         r_mcand <= '0;
         r_mpl   <= '0;
         r_q     <= '0;
         r_rem   <= '0;
         r_s     <= '0;
         r_z     <= 1'b0;
         r_ov    <= 1'b0;
         r_cout  <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start && !r_busy) begin
                  r_a     <= bus.A;
                  r_b     <= bus.B;
                  r_cin   <= bus.Cin;
                  r_bin   <= bus.Bin;
                  r_sel   <= bus.Sel;
                  r_acc   <= '0;
                  r_mcand <= {{N{1'b0}}, bus.A};
                  r_mpl   <= bus.B;
                  r_q     <= bus.A;
                  r_rem   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= w_go_calc ? ST_CALC : ST_DONE;
               end
            end
            ST_CALC: begin
               // Multiplier and divider datapaths both advance; r_sel picks
               // which one is published.
               if (r_mpl[0]) r_acc <= r_acc + r_mcand;
               r_mcand <= r_mcand << 1;
               r_mpl   <= r_mpl >> 1;
               r_rem   <= w_ge ? N'(w_trial - {1'b0, r_b}) : w_trial[N-1:0];
               r_q     <= {r_q[N-2:0], w_ge};
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(N - 1)) r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_s     <= w_s;
               r_z     <= (w_s == '0);
               r_ov    <= w_ov;
               r_cout  <= w_cout;
               r_err   <= w_err;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.S    = r_s;
   assign bus.Z    = r_z;
   assign bus.OV   = r_ov;
   assign bus.COUT = r_cout;
   assign bus.ERR  = r_err;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
endmodule

// File: tb/tb_ula_sequencial.sv
// ----------------------------------------------------------------------------
// tb_ula_sequencial
// Directed-vector bench for ula_sequencial at N=4 with hand-computed
// expectations. Honours ULA_RESTO_EN for the Sel=111 vector.
// ----------------------------------------------------------------------------
module tb_ula_sequencial;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   ula_sequencial_if #(.N(4)) bus ();

   ula_sequencial #(.N(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one op; operands are scrambled right after acceptance to show they
   // were latched. poke raises start again two edges later (must be ignored).
   task automatic do_op(input string tag, input logic [2:0] sel,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic cin, input logic bin, input bit poke,
                        input int exp_lat, input logic [7:0] exp_s,
                        input logic exp_z, input logic exp_ov,
                        input logic exp_cout, input logic exp_err);
      int cyc;
      bus.Sel = sel; bus.A = a; bus.B = b; bus.Cin = cin; bus.Bin = bin;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      bus.A = ~a; bus.B = ~b; bus.Sel = ~sel; bus.Cin = ~cin; bus.Bin = ~bin;
      check_eq({tag, ".busy_after_start"}, bus.busy, 1);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 20) begin
         if (poke && cyc == 1) bus.start = 1'b1;
         tick;
         cyc++;
         bus.start = 1'b0;
      end
      check_eq({tag, ".latency"}, cyc, exp_lat);
      check_eq({tag, ".S"}, bus.S, exp_s);
      check_eq({tag, ".Z"}, bus.Z, exp_z);
      check_eq({tag, ".OV"}, bus.OV, exp_ov);
      check_eq({tag, ".COUT"}, bus.COUT, exp_cout);
      check_eq({tag, ".ERR"}, bus.ERR, exp_err);
      check_eq({tag, ".busy_at_done"}, bus.busy, 0);
      tick;
      check_eq({tag, ".done_pulse"}, bus.done, 0);
      check_eq({tag, ".S_hold"}, bus.S, exp_s);
      check_eq({tag, ".idle_after"}, bus.busy, 0);
   endtask

   initial begin
      bit saw_done;
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.Bin = 1'b0;
      bus.Sel = '0;
      repeat (3) tick;
      check_eq("rst.S", bus.S, 0);
      check_eq("rst.flags", {bus.Z, bus.OV, bus.COUT, bus.ERR}, 0);
      check_eq("rst.busy_done", {bus.busy, bus.done}, 0);
      rst = 1'b0;
      tick;

      //      tag         sel     A      B     cin bin poke lat S      Z  OV COUT ERR
      do_op("soma_9_8_1", 3'b000, 4'h9, 4'h8, 1, 0, 0, 1, 8'h12, 0, 1, 1, 0);
      do_op("soma_7_1",   3'b000, 4'h7, 4'h1, 0, 0, 0, 1, 8'h08, 0, 1, 0, 0);
      do_op("sub_3_5",    3'b001, 4'h3, 4'h5, 0, 0, 0, 1, 8'h1E, 0, 0, 1, 0);
      do_op("sub_8_1",    3'b001, 4'h8, 4'h1, 0, 0, 0, 1, 8'h07, 0, 1, 0, 0);
      do_op("sub_5_4_b",  3'b001, 4'h5, 4'h4, 0, 1, 0, 1, 8'h00, 1, 0, 0, 0);
      do_op("mult_15_15", 3'b010, 4'hF, 4'hF, 0, 0, 1, 5, 8'hE1, 0, 1, 0, 0);
      do_op("mult_3_5",   3'b010, 4'h3, 4'h5, 0, 0, 0, 5, 8'h0F, 0, 0, 0, 0);
      do_op("mult_0_0",   3'b010, 4'h0, 4'h0, 0, 0, 0, 5, 8'h00, 1, 0, 0, 0);
      do_op("div_13_4",   3'b011, 4'hD, 4'h4, 0, 0, 0, 5, 8'h03, 0, 0, 0, 0);
      do_op("div_15_1",   3'b011, 4'hF, 4'h1, 0, 0, 0, 5, 8'h0F, 0, 0, 0, 0);
      do_op("div_2_7",    3'b011, 4'h2, 4'h7, 0, 0, 0, 5, 8'h00, 1, 0, 0, 0);
`ifdef ULA_RESTO_EN
      do_op("resto_13_4", 3'b111, 4'hD, 4'h4, 0, 0, 0, 5, 8'h01, 0, 0, 0, 0);
      do_op("resto_7_0",  3'b111, 4'h7, 4'h0, 0, 0, 0, 1, 8'h00, 1, 0, 0, 1);
`else
      do_op("resto_13_4", 3'b111, 4'hD, 4'h4, 0, 0, 0, 1, 8'h00, 1, 0, 0, 1);
`endif
      do_op("div_7_0",    3'b011, 4'h7, 4'h0, 0, 0, 0, 1, 8'h00, 1, 0, 0, 1);
      do_op("xor_A_A",    3'b110, 4'hA, 4'hA, 0, 0, 0, 1, 8'h00, 1, 0, 0, 0);
      do_op("and_C_A",    3'b100, 4'hC, 4'hA, 0, 0, 0, 1, 8'h08, 0, 0, 0, 0);
      do_op("or_C_A",     3'b101, 4'hC, 4'hA, 0, 0, 0, 1, 8'h0E, 0, 0, 0, 0);

      // start held high: second op is accepted only on the edge after done
      bus.Sel = 3'b000; bus.A = 4'h1; bus.B = 4'h2; bus.Cin = 1'b0;
      bus.start = 1'b1;
      tick;
      check_eq("hold.busy_t", bus.busy, 1);
      tick;
      check_eq("hold.done_t1", {bus.done, bus.busy}, 2'b10);
      check_eq("hold.S_t1", bus.S, 8'h03);
      tick;
      check_eq("hold.reaccept_t2", {bus.done, bus.busy}, 2'b01);
      bus.start = 1'b0;
      tick;
      check_eq("hold.done_t3", bus.done, 1);
      tick;

      // reset in the middle of a mult aborts it without a done pulse
      bus.Sel = 3'b010; bus.A = 4'hF; bus.B = 4'hF;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check_eq("abort.S", bus.S, 0);
      check_eq("abort.flags", {bus.Z, bus.OV, bus.COUT, bus.ERR}, 0);
      check_eq("abort.busy_done", {bus.busy, bus.done}, 0);
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
      end
      check_eq("abort.no_done", saw_done, 0);
      do_op("soma_5_6", 3'b000, 4'h5, 4'h6, 0, 0, 0, 1, 8'h0B, 0, 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
